// File: rtl/dma_scheduler.sv
// dma_scheduler: round-robin sharing of one DMA controller between up to four requesters.
// Programs the DMA control word over Wishbone, waits for the completion IRQ and watchdogs hung transfers.
module dma_scheduler #(
   parameter int          NREQ    = 4,
   parameter logic [15:0] DMA_ADR = 16'h0000,
   parameter int          TIMEOUT = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NREQ-1:0]      req_i,
   input  logic [NREQ*28-1:0]   desc_i,
   output logic [NREQ-1:0]      done_o,
   output logic [NREQ-1:0]      err_o,
   output logic                 busy_o,
   output logic [1:0]           grant_o,
   output logic                 wbm_cyc_o,
   output logic                 wbm_stb_o,
   output logic                 wbm_we_o,
   output logic [3:0]           wbm_sel_o,
   output logic [15:0]          wbm_adr_o,
   output logic [31:0]          wbm_dat_o,
   input  logic                 wbm_ack_i,
   input  logic                 dma_irq_i
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GRANT = 3'd1,
      S_WRITE = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4,
      S_ABORT = 3'd5
   } state_t;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t      state_r, state_nxt_s;
   logic [15:0] cnt_r;
   logic [1:0]  rr_start_r;
   logic [3:0]  req_pad_s;
   logic [27:0] desc_arr_s [4];
   logic [2:0]  scan_idx_s;
   logic        pick_found_s;
   logic [1:0]  pick_idx_s;
   logic        wb_on_s;
   logic [1:0]  grant_nxt_s;
   logic [31:0] dat_nxt_s;
   logic [3:0]  done_nxt_s, err_nxt_s;
   logic        wb_r, busy_r;
   logic [1:0]  grant_r;
   logic [31:0] dat_r;
   logic [NREQ-1:0] done_r, err_r;

   // Reserved descriptor bits [1:0] are dropped; addresses gain a zero MSB to fill a byte.
   function automatic logic [31:0] ctrl_word(input logic [27:0] d);
      return {1'b1, 3'b000, d[27:26], d[25:24], d[23:16], 1'b0, d[15:9], 1'b0, d[8:2]};
   endfunction

   function automatic logic [3:0] onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   function automatic logic [1:0] rr_after(input logic [1:0] g);
      logic [2:0] n;
      n = {1'b0, g} + 3'd1;
      if (n >= 3'(NREQ)) begin
         return 2'd0;
      end else begin
         return n[1:0];
      end
   endfunction

   // Pad requests/descriptors to four slots so unused slots can never win.
   always_comb begin
      req_pad_s = 4'b0000;
      req_pad_s[NREQ-1:0] = req_i;
      for (int k = 0; k < 4; k++) begin
         desc_arr_s[k] = 28'd0;
      end
      for (int k = 0; k < NREQ; k++) begin
         desc_arr_s[k] = desc_i[28*k +: 28];
      end
   end

   // Round-robin scan: first pending request at or after rr_start_r, wrapping modulo NREQ.
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = 2'd0;
      scan_idx_s   = 3'd0;
      for (int i = 0; i < NREQ; i++) begin
         scan_idx_s = 3'(rr_start_r) + 3'(i);
         if (scan_idx_s >= 3'(NREQ)) begin
            scan_idx_s = scan_idx_s - 3'(NREQ);
         end else begin
            scan_idx_s = scan_idx_s;
         end
         if (!pick_found_s && req_pad_s[scan_idx_s[1:0]]) begin
            pick_found_s = 1'b1;
            pick_idx_s   = scan_idx_s[1:0];
         end else begin
            pick_found_s = pick_found_s;
            pick_idx_s   = pick_idx_s;
         end
      end
   end

   // State register, watchdog counter and round-robin start pointer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r    <= S_IDLE;
         cnt_r      <= 16'd0;
         rr_start_r <= 2'd0;
      end else begin
         state_r <= state_nxt_s;
         if (state_r == S_WRITE && wbm_ack_i) begin
            cnt_r <= 16'd0;
         end else if (state_r == S_WAIT) begin
            cnt_r <= cnt_r + 16'd1;
         end else begin
            cnt_r <= cnt_r;
         end
         if (state_r == S_DONE || state_r == S_ABORT) begin
            rr_start_r <= rr_after(grant_r);
         end else begin
            rr_start_r <= rr_start_r;
         end
      end
   end

   // Next-state logic; an IRQ on the final watchdog cycle still counts as completion.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE:  state_nxt_s = (|req_i) ? S_GRANT : S_IDLE;
         S_GRANT: state_nxt_s = pick_found_s ? S_WRITE : S_IDLE;
         S_WRITE: state_nxt_s = wbm_ack_i ? S_WAIT : S_WRITE;
         S_WAIT: begin
            if (dma_irq_i) begin
               state_nxt_s = S_DONE;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = S_ABORT;
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         S_DONE:  state_nxt_s = S_IDLE;
         S_ABORT: state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Output next values, registered below so every output comes straight from a flop.
   always_comb begin
      wb_on_s = (state_nxt_s == S_WRITE);
      if (state_r == S_GRANT && pick_found_s) begin
         grant_nxt_s = pick_idx_s;
      end else begin
         grant_nxt_s = grant_r;
      end
      if (!wb_on_s) begin
         dat_nxt_s = 32'd0;
      end else if (state_r == S_GRANT) begin
         dat_nxt_s = ctrl_word(desc_arr_s[pick_idx_s]);
      end else begin
         dat_nxt_s = dat_r;
      end
      if (state_nxt_s == S_DONE) begin
         done_nxt_s = onehot(grant_r);
      end else begin
         done_nxt_s = 4'b0000;
      end
      if (state_nxt_s == S_ABORT) begin
         err_nxt_s = onehot(grant_r);
      end else begin
         err_nxt_s = 4'b0000;
      end
   end

   // Output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wb_r    <= 1'b0;
         busy_r  <= 1'b0;
         grant_r <= 2'd0;
         dat_r   <= 32'd0;
         done_r  <= '0;
         err_r   <= '0;
      end else begin
         wb_r    <= wb_on_s;
         busy_r  <= (state_nxt_s != S_IDLE);
         grant_r <= grant_nxt_s;
         dat_r   <= dat_nxt_s;
         done_r  <= done_nxt_s[NREQ-1:0];
         err_r   <= err_nxt_s[NREQ-1:0];
      end
   end

   assign wbm_cyc_o = wb_r;
   assign wbm_stb_o = wb_r;
   assign wbm_we_o  = wb_r;
   assign wbm_sel_o = wb_r ? 4'hF : 4'h0;
   assign wbm_adr_o = wb_r ? DMA_ADR : 16'h0000;
   assign wbm_dat_o = dat_r;
   assign busy_o    = busy_r;
   assign grant_o   = grant_r;
   assign done_o    = done_r;
   assign err_o     = err_r;

endmodule

// File: tb/tb_dma_scheduler.sv
// Self-checking bench for dma_scheduler: directed scenarios plus randomized transfers
// compared against a transaction-level round-robin / watchdog model.
module tb_dma_scheduler;

   localparam int          NREQ    = 4;
   localparam logic [15:0] DMA_ADR = 16'hA5C0;
   localparam int          TIMEOUT = 16;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [3:0]    req_i;
   logic [111:0]  desc_i;
   logic [3:0]    done_o, err_o;
   logic          busy_o;
   logic [1:0]    grant_o;
   logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]    wbm_sel_o;
   logic [15:0]   wbm_adr_o;
   logic [31:0]   wbm_dat_o;
   logic          wbm_ack_i, dma_irq_i;
   logic [27:0]   desc_v [4];

   int checks = 0;
   int errors = 0;
   int last_g;
   int g_seen;
   logic [31:0] w_seen;

   always #5 clk_i = ~clk_i;
   assign desc_i = {desc_v[3], desc_v[2], desc_v[1], desc_v[0]};

   dma_scheduler #(.NREQ(NREQ), .DMA_ADR(DMA_ADR), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .desc_i(desc_i),
      .done_o(done_o), .err_o(err_o), .busy_o(busy_o), .grant_o(grant_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_ack_i(wbm_ack_i), .dma_irq_i(dma_irq_i)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: first pending requester after the last granted one, wrapping.
   function automatic int model_pick(input logic [3:0] r, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         int c;
         c = (last + k) % NREQ;
         if (r[c]) return c;
      end
      return 0;
   endfunction

   function automatic logic [31:0] model_word(input logic [27:0] d);
      int unsigned w;
      w = 32'h8000_0000;
      w += int'(d[27:26]) * (1 << 26);
      w += int'(d[25:24]) * (1 << 24);
      w += int'(d[23:16]) * (1 << 16);
      w += int'(d[15:9]) * (1 << 8);
      w += int'(d[8:2]);
      return 32'(w);
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, 64'({done_o, err_o, busy_o, grant_o, wbm_cyc_o, wbm_stb_o,
                                wbm_we_o, wbm_sel_o}), 64'd0);
      check({tag, "_bus"}, 64'({wbm_adr_o, wbm_dat_o}), 64'd0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1; req_i = 4'b0000; wbm_ack_i = 1'b0; dma_irq_i = 1'b0;
      repeat (2) tick();
      rst_i = 1'b0;
      last_g = NREQ - 1;
      tick();
   endtask

   // One complete transfer: request already on req_i. irq_at < 0 means no IRQ in WAIT.
   task automatic run_xfer(input int ack_dly, input int irq_at, input bit hold, input bit late_irq,
                           input string tag, output int gs, output logic [31:0] ws);
      int eg, lat, term_k;
      logic [31:0] ew;
      logic [3:0] pulse;
      bit irq_ok;
      eg = model_pick(req_i, last_g);
      ew = model_word(desc_v[eg]);
      lat = 0;
      while (!wbm_stb_o && lat < 8) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'd2);
      gs = int'(grant_o);
      ws = wbm_dat_o;
      check({tag, "_grant"}, 64'(grant_o), 64'(eg));
      check({tag, "_word"}, 64'(wbm_dat_o), 64'(ew));
      check({tag, "_bus"}, 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o}),
            64'({3'b111, 4'hF, DMA_ADR}));
      for (int i = 0; i < ack_dly; i++) begin
         tick();
         check({tag, "_hold"}, 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_dat_o}),
               64'({3'b111, 4'hF, ew}));
      end
      wbm_ack_i = 1'b1;
      tick();
      wbm_ack_i = 1'b0;
      check({tag, "_drop"}, 64'({wbm_cyc_o, wbm_stb_o, busy_o}), 64'(3'b001));
      irq_ok = (irq_at >= 0) && (irq_at <= TIMEOUT - 1);
      term_k = irq_ok ? irq_at : TIMEOUT - 1;
      pulse = 4'b0001 << eg;
      for (int k = 0; k <= term_k; k++) begin
         dma_irq_i = (k == irq_at);
         tick();
         if (k == term_k) begin
            check({tag, "_end"}, 64'({wbm_stb_o, done_o, err_o}),
                  irq_ok ? 64'({1'b0, pulse, 4'b0000}) : 64'({1'b0, 4'b0000, pulse}));
         end else begin
            check({tag, "_wait"}, 64'({wbm_stb_o, done_o, err_o}), 64'd0);
         end
      end
      dma_irq_i = late_irq;
      last_g = eg;
      if (!hold) req_i[eg] = 1'b0;
      tick();
      dma_irq_i = 1'b0;
      check({tag, "_idle"}, 64'({done_o, err_o, busy_o, wbm_stb_o}), 64'd0);
   endtask

   initial begin
      rst_i = 1'b0; req_i = 4'b0000; wbm_ack_i = 1'b0; dma_irq_i = 1'b0;
      for (int i = 0; i < 4; i++) desc_v[i] = 28'd0;
      #2;
      rst_i = 1'b1;
      #1;
      check_all_zero("reset");
      do_reset();
      check_all_zero("post_reset");

      // Single request with a known descriptor.
      desc_v[1] = {2'd0, 2'd3, 8'h10, 7'h05, 7'h40, 2'b00};
      req_i = 4'b0010;
      run_xfer(0, 10, 1'b0, 1'b0, "single", g_seen, w_seen);
      check("single_word_const", 64'(w_seen), 64'h8310_0540);
      check("single_grant_const", 64'(g_seen), 64'd1);

      // Round-robin with every requester pending.
      do_reset();
      for (int i = 0; i < 4; i++) desc_v[i] = 28'($urandom());
      req_i = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         run_xfer(0, int'($urandom_range(0, 12)), 1'b1, 1'b0, "rr", g_seen, w_seen);
         check("rr_order", 64'(g_seen), 64'(i % 4));
      end
      req_i = 4'b0000;
      tick();

      // Five Wishbone wait states.
      desc_v[2] = 28'($urandom());
      req_i = 4'b0100;
      run_xfer(5, 4, 1'b0, 1'b0, "wstate", g_seen, w_seen);

      // Watchdog expiry followed by a late IRQ.
      req_i = 4'b1000;
      run_xfer(1, -1, 1'b0, 1'b1, "timeout", g_seen, w_seen);

      // IRQ on the final watchdog cycle.
      req_i = 4'b0001;
      run_xfer(0, TIMEOUT - 1, 1'b0, 1'b0, "coincide", g_seen, w_seen);

      // Randomized transfers.
      for (int n = 0; n < 16; n++) begin
         int ia;
         for (int i = 0; i < 4; i++) desc_v[i] = 28'($urandom());
         req_i = 4'($urandom_range(1, 15));
         ia = int'($urandom_range(0, TIMEOUT + 3));
         run_xfer(int'($urandom_range(0, 3)), (ia >= TIMEOUT) ? -1 : ia, 1'b0, ia >= TIMEOUT,
                  "rand", g_seen, w_seen);
         req_i = 4'b0000;
      end

      // Asynchronous reset while waiting for the IRQ.
      desc_v[2] = 28'($urandom());
      req_i = 4'b0100;
      for (int i = 0; i < 8 && !wbm_stb_o; i++) tick();
      check("rstw_stb", 64'(wbm_stb_o), 64'd1);
      wbm_ack_i = 1'b1;
      tick();
      wbm_ack_i = 1'b0;
      repeat (3) tick();
      check("rstw_pre", 64'({busy_o, grant_o}), 64'({1'b1, 2'd2}));
      #2;
      rst_i = 1'b1;
      #1;
      check_all_zero("rstw_async");
      req_i = 4'b0000;
      repeat (2) begin
         tick();
         check("rstw_held", 64'({done_o, err_o, busy_o}), 64'd0);
      end
      rst_i = 1'b0;
      last_g = NREQ - 1;
      tick();
      check("rstw_after", 64'({done_o, err_o, busy_o}), 64'd0);
      req_i = 4'b0001;
      run_xfer(0, 3, 1'b0, 1'b0, "rstw_xfer", g_seen, w_seen);
      check("rstw_grant0", 64'(g_seen), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
